// File: rtl/micro_ucr_verify.sv
// micro-ucr-hash proof-of-work checker: recomputes the 24-bit hash and checks it against the target.
// Define MICRO_UCR_VERIFY_UNROLL2_EN to run two rounds per cycle.
module micro_ucr_verify (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [95:0] payload,
  input  logic [31:0] nonce,
  input  logic [7:0]  target,
  output logic        busy,
  output logic        done,
  output logic [23:0] hash,
  output logic        valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL
  } state_t;

`ifdef MICRO_UCR_VERIFY_UNROLL2_EN
  localparam logic [4:0] STEP = 5'd2;
  localparam logic [4:0] LAST = 5'd30;
`else
  localparam logic [4:0] STEP = 5'd1;
  localparam logic [4:0] LAST = 5'd31;
`endif

  state_t r_state;
  state_t w_next;

  logic [127:0] r_win;
  logic [7:0]   r_a;
  logic [7:0]   r_b;
  logic [7:0]   r_c;
  logic [7:0]   r_tgt;
  logic [4:0]   r_cnt;
  logic         r_done;
  logic [23:0]  r_hash;
  logic         r_valid;

  logic [7:0]   w_n0;
  logic [23:0]  w_abc1;
  logic [23:0]  w_abc;
  logic [127:0] w_win_nx;
  logic [23:0]  w_h;
  logic         w_ok;

  function automatic logic [23:0] f_round(
    input logic [23:0] abc,
    input logic [7:0]  w,
    input logic        late
  );
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] q;
    logic [7:0] k;
    logic [7:0] s;
    a = abc[23:16];
    b = abc[15:8];
    c = abc[7:0];
    q = late ? (a | b) : (a ^ b);
    k = late ? 8'ha1 : 8'h99;
    s = q + k + w;
    return {a ^ b ^ a ^ b ^ b ^ c, c[3:0], 4'h0, s};
  endfunction

  // window byte j sits at r_win[127-8j -: 8]; w[i+16] = w[i+13] | (w[i+7] ^ w[i+2])
  assign w_n0 = r_win[23:16] | (r_win[71:64] ^ r_win[111:104]);

`ifdef MICRO_UCR_VERIFY_UNROLL2_EN
  logic [7:0] w_n1;
  assign w_n1 = r_win[15:8] | (r_win[63:56] ^ r_win[103:96]);

  always_comb begin
    w_abc1   = f_round({r_a, r_b, r_c}, r_win[127:120], r_cnt > 5'd16);
    w_abc    = f_round(w_abc1, r_win[119:112], r_cnt >= 5'd16);
    w_win_nx = {r_win[111:0], w_n0, w_n1};
  end
`else
  always_comb begin
    w_abc1   = f_round({r_a, r_b, r_c}, r_win[127:120], r_cnt > 5'd16);
    w_abc    = w_abc1;
    w_win_nx = {r_win[119:0], w_n0};
  end
`endif

  assign w_h  = {8'h01 + r_a, 8'h89 + r_b, 8'hfe + r_c};
  assign w_ok = (w_h[7:0] < r_tgt) && (w_h[15:8] < r_tgt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ROUND;
      S_ROUND: if (r_cnt == LAST) w_next = S_FINAL;
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hash  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_win <= {payload, nonce};
            r_tgt <= target;
            r_a   <= 8'h01;
            r_b   <= 8'h89;
            r_c   <= 8'hfe;
            r_cnt <= '0;
          end
        end
        S_ROUND: begin
          {r_a, r_b, r_c} <= w_abc;
          r_win <= w_win_nx;
          r_cnt <= r_cnt + STEP;
        end
        S_FINAL: begin
          r_hash  <= w_h;
          r_valid <= w_ok;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign hash  = r_hash;
  assign valid = r_valid;

endmodule

// File: tb/tb_micro_ucr_verify.sv
// Self-checking bench for micro_ucr_verify: vector table, corner sequences
// and random vectors against an array-based reference of the hash.
module tb_micro_ucr_verify;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [95:0] payload;
  logic [31:0] nonce;
  logic [7:0]  target;
  logic        busy;
  logic        done;
  logic [23:0] hash;
  logic        valid;

  int errors = 0;
  int checks = 0;

`ifdef MICRO_UCR_VERIFY_UNROLL2_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  micro_ucr_verify dut (
    .clk(clk), .reset(reset), .start(start),
    .payload(payload), .nonce(nonce), .target(target),
    .busy(busy), .done(done), .hash(hash), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] p;
    logic [31:0] n;
    logic [7:0]  t;
    logic [23:0] eh;
    logic        ev;
  } vec_t;

  function automatic logic [23:0] ref_hash(input logic [95:0] p,
                                           input logic [31:0] n);
    logic [127:0] blk;
    logic [7:0]   w [32];
    int a, b, c, q, k, na, nb;
    blk = {p, n};
    for (int i = 0; i < 16; i++) w[i] = blk[127-8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 1; b = 'h89; c = 'hfe;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin k = 'h99; q = a ^ b; end
      else begin k = 'ha1; q = a | b; end
      na = b ^ c;
      nb = (c * 16) % 256;
      c  = (q + k + int'(w[i])) % 256;
      a  = na;
      b  = nb;
    end
    return {8'((1 + a) % 256), 8'((137 + b) % 256), 8'((254 + c) % 256)};
  endfunction

  function automatic logic ref_valid(input logic [23:0] h, input logic [7:0] t);
    return (h[7:0] < t) && (h[15:8] < t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic do_check(input logic [95:0] p, input logic [31:0] n,
                          input logic [7:0] t, input logic [23:0] eh,
                          input logic ev, input string tag);
    int  cyc;
    bit  got;
    payload = p; nonce = n; target = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_after_E0"}, 32'(busy), 32'd1);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    payload = ~p; nonce = ~n; target = ~t;
    cyc = 0; got = 0;
    while (cyc < LAT + 10 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
    end
    chk({tag, " latency"}, got ? cyc : -1, LAT);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, " hash"}, 32'(hash), 32'(eh));
    chk({tag, " valid"}, 32'(valid), 32'(ev));
  endtask

  initial begin
    vec_t        tbl[6];
    logic [23:0] g;
    logic [7:0]  mx;
    logic [95:0] bp[120];
    logic [31:0] bn[120];
    int          d1, d2, nd;
    logic [23:0] h1, h2;
    logic        v1, v2;

    reset = 1'b1; start = 1'b0;
    payload = '0; nonce = '0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst hash", 32'(hash), 0);
    chk("rst valid", 32'(valid), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    g  = ref_hash(96'h0, 32'h01001b23);
    mx = (g[7:0] > g[15:8]) ? g[7:0] : g[15:8];
    tbl[0] = '{96'h0, 32'h01001b23, 8'hff, g, ref_valid(g, 8'hff)};
    tbl[1] = '{96'h0, 32'h01001b23, 8'h00, g, 1'b0};
    tbl[2] = '{96'h0, 32'h01001b23, (mx < 8'hff) ? mx + 8'd1 : 8'hff, g,
               (mx < 8'hff) ? 1'b1 : ref_valid(g, 8'hff)};
    tbl[3] = '{96'h0, 32'h01001b23, mx, g, 1'b0};
    g = ref_hash({3{32'hffffffff}}, 32'hdeadbeef);
    tbl[4] = '{{3{32'hffffffff}}, 32'hdeadbeef, 8'h7f, g, ref_valid(g, 8'h7f)};
    g = ref_hash(96'h0123456789abcdef01234567, 32'h0);
    tbl[5] = '{96'h0123456789abcdef01234567, 32'h0, 8'hff, g, ref_valid(g, 8'hff)};
    for (int i = 0; i < 6; i++)
      do_check(tbl[i].p, tbl[i].n, tbl[i].t, tbl[i].eh, tbl[i].ev,
               $sformatf("tbl%0d", i));

    payload = 96'h5a5a; nonce = 32'h1234; target = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst hash", 32'(hash), 0);
    chk("midrst valid", 32'(valid), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst no_done", nd, 0);
    g = ref_hash(96'h0, 32'h01001b23);
    do_check(96'h0, 32'h01001b23, 8'hff, g, ref_valid(g, 8'hff), "post_rst");

    d1 = -1; d2 = -1; h1 = '0; h2 = '0; v1 = 0; v2 = 0;
    target = 8'h80;
    for (int k = 0; k < 120; k++) begin
      bp[k] = {$urandom, $urandom, $urandom};
      bn[k] = $urandom;
      payload = bp[k]; nonce = bn[k];
      start = (k < 40);
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) begin d1 = k; h1 = hash; v1 = valid; end
        else if (d2 < 0) begin d2 = k; h2 = hash; v2 = valid; end
      end
    end
    start = 1'b0;
    chk("busy first_done", d1, LAT);
    chk("busy second_done", d2, 2 * LAT + 1);
    g = ref_hash(bp[0], bn[0]);
    chk("busy hash1", 32'(h1), 32'(g));
    chk("busy valid1", 32'(v1), 32'(ref_valid(g, 8'h80)));
    g = ref_hash(bp[LAT+1], bn[LAT+1]);
    chk("busy hash2", 32'(h2), 32'(g));
    chk("busy valid2", 32'(v2), 32'(ref_valid(g, 8'h80)));

    for (int r = 0; r < 1000; r++) begin
      logic [95:0] rp;
      logic [31:0] rn;
      logic [7:0]  rt;
      rp = {$urandom, $urandom, $urandom};
      rn = $urandom;
      rt = 8'($urandom_range(0, 255));
      g  = ref_hash(rp, rn);
      do_check(rp, rn, rt, g, ref_valid(g, rt), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
